// File: rtl/tri_raster_seq_if.sv
// tri_raster_seq_if: triangle-setup + pixel stream bundle for tri_raster_seq.
//   start, p1x..p3y : scan request and vertex coordinates (source -> rasteriser)
//   busy, done      : scan status (rasteriser -> source)
//   out_valid/ready : pixel stream handshake; out_x/out_y carry the pixel
//   pix_count       : pixels emitted in the current or last scan
// master = triangle source / pixel consumer side, slave = rasteriser.
interface tri_raster_seq_if #(parameter int W = 11);
  logic           start;
  logic [W-1:0]   p1x, p1y, p2x, p2y, p3x, p3y;
  logic           busy, done;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_x, out_y;
  logic [2*W-1:0] pix_count;

  modport master (output start, p1x, p1y, p2x, p2y, p3x, p3y, out_ready,
                  input  busy, done, out_valid, out_x, out_y, pix_count);
  modport slave  (input  start, p1x, p1y, p2x, p2y, p3x, p3y, out_ready,
                  output busy, done, out_valid, out_x, out_y, pix_count);
endinterface

// File: rtl/tri_raster_seq.sv
// tri_raster_seq: sequential point-in-triangle rasteriser.
//   Latches three vertices on start, scans the bounding box in raster order,
//   evaluates the three edge functions of each pixel on one shared unit
//   (3 cycles/pixel) and streams inside/on-edge pixels out valid/ready.
// Ports: clk, rst_n (async, active low), bus (tri_raster_seq_if.slave).
// Optional: define TRI_RASTER_CULL_EN to add an AREA state that rejects
//   degenerate (zero-area) triangles without scanning.
module tri_raster_seq #(parameter int W = 11) (
  input  logic            clk,
  input  logic            rst_n,
  tri_raster_seq_if.slave bus
);
  localparam int PW = 2*W+2;  // product width
  localparam int EW = 2*W+3;  // edge-function width

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_AREA, S_EVAL, S_EMIT, S_DONE} state_t;

  state_t            r_state;
  logic [2:0][W-1:0] r_vx, r_vy;
  logic [W-1:0]      r_xmin, r_xmax, r_ymax;
  logic [W-1:0]      r_cx, r_cy;
  logic [1:0]        r_e;
  logic              r_any_neg, r_any_pos;
  logic              r_busy, r_done, r_valid;
  logic [2*W-1:0]    r_cnt;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // shared edge unit: E(a, b, p) = (ax-px)(by-py) - (bx-px)(ay-py)
  logic [W-1:0]        w_ax, w_ay, w_bx, w_by, w_px, w_py;
  logic signed [W:0]   w_d0, w_d1, w_d2, w_d3;
  logic signed [PW-1:0] w_m0, w_m1;
  logic signed [EW-1:0] w_e;

  always_comb begin
    w_ax = r_cx;    w_ay = r_cy;
    w_bx = r_vx[0]; w_by = r_vy[0];
    w_px = r_vx[1]; w_py = r_vy[1];
    if (r_state == S_AREA) begin
      w_ax = r_vx[0]; w_ay = r_vy[0];
      w_bx = r_vx[1]; w_by = r_vy[1];
      w_px = r_vx[2]; w_py = r_vy[2];
    end else begin
      case (r_e)
        2'd1:    begin w_bx = r_vx[1]; w_by = r_vy[1]; w_px = r_vx[2]; w_py = r_vy[2]; end
        2'd2:    begin w_bx = r_vx[2]; w_by = r_vy[2]; w_px = r_vx[0]; w_py = r_vy[0]; end
        default: begin w_bx = r_vx[0]; w_by = r_vy[0]; w_px = r_vx[1]; w_py = r_vy[1]; end
      endcase
    end
  end

  assign w_d0 = $signed({1'b0, w_ax}) - $signed({1'b0, w_px});
  assign w_d1 = $signed({1'b0, w_by}) - $signed({1'b0, w_py});
  assign w_d2 = $signed({1'b0, w_bx}) - $signed({1'b0, w_px});
  assign w_d3 = $signed({1'b0, w_ay}) - $signed({1'b0, w_py});
  assign w_m0 = PW'(w_d0) * PW'(w_d1);
  assign w_m1 = PW'(w_d2) * PW'(w_d3);
  assign w_e  = EW'(w_m0) - EW'(w_m1);

  logic w_neg, w_pos, w_an, w_ap, w_inside, w_last, w_eol;
  logic [W-1:0] w_nx, w_ny;

  assign w_neg    = w_e[EW-1];
  assign w_pos    = !w_neg && (w_e != '0);
  assign w_an     = r_any_neg | w_neg;
  assign w_ap     = r_any_pos | w_pos;
  assign w_inside = !(w_an && w_ap);
  // end-of-row / end-of-box tested on the current cursor so nothing wraps at 2^W-1
  assign w_eol    = (r_cx == r_xmax);
  assign w_last   = w_eol && (r_cy == r_ymax);
  assign w_nx     = w_eol ? r_xmin : r_cx + 1'b1;
  assign w_ny     = w_eol ? r_cy + 1'b1 : r_cy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vx      <= '0;
      r_vy      <= '0;
      r_xmin    <= '0;
      r_xmax    <= '0;
      r_ymax    <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_e       <= '0;
      r_any_neg <= 1'b0;
      r_any_pos <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start) begin
            r_vx    <= {bus.p3x, bus.p2x, bus.p1x};
            r_vy    <= {bus.p3y, bus.p2y, bus.p1y};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_xmin    <= min3(r_vx[0], r_vx[1], r_vx[2]);
          r_xmax    <= max3(r_vx[0], r_vx[1], r_vx[2]);
          r_ymax    <= max3(r_vy[0], r_vy[1], r_vy[2]);
          r_cx      <= min3(r_vx[0], r_vx[1], r_vx[2]);
          r_cy      <= min3(r_vy[0], r_vy[1], r_vy[2]);
          r_e       <= 2'd0;
          r_any_neg <= 1'b0;
          r_any_pos <= 1'b0;
`ifdef TRI_RASTER_CULL_EN
          r_state   <= S_AREA;
`else
          r_state   <= S_EVAL;
`endif
        end
`ifdef TRI_RASTER_CULL_EN
        S_AREA: r_state <= (w_e == '0) ? S_DONE : S_EVAL;
`endif
        S_EVAL: begin
          if (r_e != 2'd2) begin
            r_e       <= r_e + 2'd1;
            r_any_neg <= w_an;
            r_any_pos <= w_ap;
          end else begin
            r_e       <= 2'd0;
            r_any_neg <= 1'b0;
            r_any_pos <= 1'b0;
            if (w_inside) begin
              r_valid <= 1'b1;
              r_state <= S_EMIT;
            end else if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_cx <= w_nx;
              r_cy <= w_ny;
            end
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_state <= S_DONE;
            else begin
              r_cx    <= w_nx;
              r_cy    <= w_ny;
              r_state <= S_EVAL;
            end
          end
        end
        S_DONE: begin
          // done rises as IDLE is re-entered; busy drops one cycle later
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out_valid = r_valid;
  assign bus.out_x     = r_cx;
  assign bus.out_y     = r_cy;
  assign bus.pix_count = r_cnt;
endmodule

// File: tb/tb_tri_raster_seq.sv
// tb_tri_raster_seq: table-driven and randomized bench for tri_raster_seq.
// Reference model enumerates the bounding box with plain loops and applies the
// edge-sign inside rule; latency expectations come from the cycle formulas.
module tb_tri_raster_seq;
  localparam int W = 11;
`ifdef TRI_RASTER_CULL_EN
  localparam int CULL = 1;
`else
  localparam int CULL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tri_raster_seq_if #(.W(W)) bus();
  tri_raster_seq #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int x1, y1, x2, y2, x3, y3;
    int mode;        // 0 ready high, 1 targeted stall, 2 random ready
    int stall_pix, stall_len;
    int inject;      // pulse start with other vertices mid-scan
    int exp_k;       // -1: model only
    int exp_done;
  } vec_t;

  typedef struct { int x; int y; } pix_t;

  int n_cmp = 0;
  int n_bad = 0;
  pix_t exp_q[$];
  int exp_n, exp_first, exp_cull;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ef(longint ax, longint ay, longint bx, longint by,
                                longint px, longint py);
    return (ax - px) * (by - py) - (bx - px) * (ay - py);
  endfunction

  function automatic void model(input vec_t v);
    int xs[3], ys[3], xmin, xmax, ymin, ymax, idx;
    longint e0, e1, e2;
    xs = '{v.x1, v.x2, v.x3};
    ys = '{v.y1, v.y2, v.y3};
    xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < xmin) xmin = xs[i];
      if (xs[i] > xmax) xmax = xs[i];
      if (ys[i] < ymin) ymin = ys[i];
      if (ys[i] > ymax) ymax = ys[i];
    end
    exp_q.delete();
    exp_first = -1;
    exp_n = (xmax - xmin + 1) * (ymax - ymin + 1);
    exp_cull = (CULL != 0) && (ef(v.x1, v.y1, v.x2, v.y2, v.x3, v.y3) == 0);
    if (exp_cull) return;
    idx = 0;
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++) begin
        e0 = ef(x, y, v.x1, v.y1, v.x2, v.y2);
        e1 = ef(x, y, v.x2, v.y2, v.x3, v.y3);
        e2 = ef(x, y, v.x3, v.y3, v.x1, v.y1);
        if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
          if (exp_first < 0) exp_first = idx;
          exp_q.push_back('{x, y});
        end
        idx++;
      end
  endfunction

  task automatic drive_verts(input int x1, y1, x2, y2, x3, y3);
    bus.p1x = W'(x1); bus.p1y = W'(y1);
    bus.p2x = W'(x2); bus.p2y = W'(y2);
    bus.p3x = W'(x3); bus.p3y = W'(y3);
  endtask

  task automatic run_scan(input int id, input vec_t v);
    pix_t got[$];
    int cyc, done_cyc, first_v, stalls, scnt, nmin, exp_done, pc;
    bit prev_stall, busy_bad, hold_bad, rdy;
    logic [W-1:0] hx, hy;
    model(v);
    got.delete();
    cyc = -1; done_cyc = -1; first_v = -1; stalls = 0; scnt = 0; pc = 0;
    prev_stall = 0; busy_bad = 0; hold_bad = 0; hx = '0; hy = '0;
    @(negedge clk);
    drive_verts(v.x1, v.y1, v.x2, v.y2, v.x3, v.y3);
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    while (done_cyc < 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin done_cyc = cyc; pc = int'(bus.pix_count); end
      if (!bus.busy) busy_bad = 1;
      if (prev_stall && !(bus.out_valid && bus.out_x == hx && bus.out_y == hy)) hold_bad = 1;
      if (bus.out_valid && first_v < 0) first_v = cyc;
      rdy = 1'b1;
      if (v.mode == 1 && bus.out_valid && got.size() == v.stall_pix && scnt < v.stall_len) begin
        rdy = 1'b0;
        scnt++;
      end
      if (v.mode == 2) rdy = ($urandom_range(0, 3) != 0);
      bus.out_ready = rdy;
      prev_stall = bus.out_valid && !rdy;
      if (prev_stall) begin stalls++; hx = bus.out_x; hy = bus.out_y; end
      if (bus.out_valid && rdy) got.push_back('{int'(bus.out_x), int'(bus.out_y)});
      if (v.inject != 0 && cyc == 15) begin
        drive_verts(100, 100, 110, 100, 100, 110);
        bus.start = 1'b1;
      end
      if (v.inject != 0 && cyc == 16) begin
        bus.start = 1'b0;
        drive_verts(v.x1, v.y1, v.x2, v.y2, v.x3, v.y3);
      end
    end
    bus.out_ready = 1'b1;
    if (done_cyc < 0) chk($sformatf("v%0d_done_timeout", id), 0, 1);
    exp_done = exp_cull ? 3 : 2 + CULL + 3 * exp_n + exp_q.size() + stalls;
    chk($sformatf("v%0d_npix", id), got.size(), exp_q.size());
    nmin = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < nmin; i++)
      chk($sformatf("v%0d_pix%0d_xy(x*4096+y)", id, i),
          got[i].x * 4096 + got[i].y, exp_q[i].x * 4096 + exp_q[i].y);
    chk($sformatf("v%0d_pix_count", id), pc, exp_q.size());
    chk($sformatf("v%0d_done_cycle", id), done_cyc, exp_done);
    chk($sformatf("v%0d_first_valid_cycle", id), first_v,
        (exp_q.size() == 0) ? -1 : 1 + CULL + 3 * (exp_first + 1));
    chk($sformatf("v%0d_busy_dropped", id), busy_bad, 0);
    chk($sformatf("v%0d_hold_unstable", id), hold_bad, 0);
    if (v.exp_k >= 0) begin
      chk($sformatf("v%0d_tbl_npix", id), got.size(), v.exp_k);
      chk($sformatf("v%0d_tbl_done", id), done_cyc, v.exp_done);
    end
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", id), bus.done, 0);
    chk($sformatf("v%0d_busy_after", id), bus.busy, 0);
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    drive_verts(0, 0, 0, 0, 0, 0);

    tbl[0] = '{10, 22, 10, 25, 13, 22, 0, 0, 0, 0, 10, (CULL != 0) ? 61 : 60};
    tbl[1] = '{10, 22, 10, 25, 13, 22, 1, 2, 5, 0, 10, (CULL != 0) ? 66 : 65};
    tbl[2] = '{5, 5, 5, 5, 5, 5, 0, 0, 0, 0, (CULL != 0) ? 0 : 1, (CULL != 0) ? 3 : 6};
    tbl[3] = '{2045, 2047, 2047, 2047, 2047, 2045, 0, 0, 0, 0, 6, (CULL != 0) ? 36 : 35};
    tbl[4] = '{10, 22, 10, 25, 13, 22, 0, 0, 0, 1, 10, (CULL != 0) ? 61 : 60};

    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_x", bus.out_x, 0);
    chk("rst_y", bus.out_y, 0);
    chk("rst_count", bus.pix_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_scan(i, tbl[i]);

    // reset while a pixel is being presented
    @(negedge clk);
    drive_verts(10, 22, 10, 25, 13, 22);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    chk("mid_rst_reach_emit", bus.out_valid, 1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_x", bus.out_x, 0);
    chk("mid_rst_y", bus.out_y, 0);
    chk("mid_rst_count", bus.pix_count, 0);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_busy", bus.busy, 0);
    chk("post_rst_idle_valid", bus.out_valid, 0);
    run_scan(5, tbl[0]);

    // randomized small triangles, some against the top of the coordinate range
    for (int r = 0; r < 20; r++) begin
      int bx, by;
      bx = (r % 4 == 3) ? 2040 : int'($urandom_range(0, 2040));
      by = (r % 5 == 4) ? 2040 : int'($urandom_range(0, 2040));
      rv.x1 = bx + int'($urandom_range(0, 7)); rv.y1 = by + int'($urandom_range(0, 7));
      rv.x2 = bx + int'($urandom_range(0, 7)); rv.y2 = by + int'($urandom_range(0, 7));
      rv.x3 = bx + int'($urandom_range(0, 7)); rv.y3 = by + int'($urandom_range(0, 7));
      rv.mode = 2; rv.stall_pix = 0; rv.stall_len = 0; rv.inject = 0;
      rv.exp_k = -1; rv.exp_done = 0;
      run_scan(100 + r, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tri_raster_seq.md
# tri_raster_seq

Sequential rasteriser controller for the point-in-triangle datapath. It latches three triangle vertices and computes their bounding box. It then scans every pixel of the box in raster order, sharing one edge-function unit (two multipliers, one subtractor) across the three edge tests of each pixel. Each pixel found inside or on an edge is emitted over a valid/ready stream. The block sits between the triangle-setup source and the pixel/fragment consumer.

## Interface

- `W`, default 11: coordinate width, unsigned.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a scan. Sampled only in IDLE.
- `p1x`, `p1y`, `p2x`, `p2y`, `p3x`, `p3y` input W each: vertices. Latched on the cycle `start` is accepted.
- `busy` output 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` output 1: one-cycle pulse at the end of a scan.
- `out_valid` output 1: an inside pixel is presented.
- `out_ready` input 1: consumer accepts the pixel.
- `out_x`, `out_y` output W each: pixel coordinate.
- `pix_count` output 2W: number of pixels emitted in the current or last scan.

## Operation

- **States:** IDLE, SETUP, (AREA), EVAL, EMIT, DONE.
- **IDLE → SETUP:** on `start`. Latch the vertices and clear `pix_count`.
- **SETUP (1 cycle):**
  - xmin/xmax = min/max of p1x, p2x, p3x; ymin/ymax likewise.
  - Set cursor (x, y) = (xmin, ymin).
- **Edge function:** E(a, b, p) = (ax − px)·(by − py) − (bx − px)·(ay − py).
  - Differences are (W+1)-bit signed.
  - Products are (2W+2)-bit signed.
  - The result is (2W+3)-bit signed. No truncation anywhere.
- **EVAL (3 cycles per pixel):** edge counter e = 0, 1, 2 computes, in order:
  - E(cursor, p1, p2)
  - E(cursor, p2, p3)
  - E(cursor, p3, p1)
  - Per-pixel flags accumulate: any_neg (some E < 0) and any_pos (some E > 0).
- **Inside rule:** inside = !(any_neg && any_pos). Zero counts as on-edge and is inside.
- **End of e = 2:**
  - If inside → EMIT.
  - Otherwise advance the cursor and stay in EVAL, or go to DONE if the last pixel.
- **EMIT:**
  - `out_valid` = 1, `out_x`/`out_y` = cursor.
  - On `out_valid && out_ready`: increment `pix_count`, then advance (or DONE).
  - Outputs hold stable while `out_ready` = 0.
- **Advance:**
  - If x == xmax: x ← xmin and y ← y + 1. Otherwise x ← x + 1.
  - The last pixel is (xmax, ymax).
  - Compare before incrementing. Counters never wrap at 2^W − 1.
- **DONE (1 cycle):** `done` = 1, then → IDLE.
- **Start while busy:** `start` outside IDLE is ignored. It is not queued.
- **Reset:** asserting `rst_n` low at any time returns to IDLE.
  - `busy`, `done`, `out_valid`, `out_x`, `out_y` and `pix_count` all go to 0.
  - A scan in progress is abandoned and no further pixels are emitted.

## Timing

- With `out_ready` held high:
  - Without the macro: `done` asserts exactly 2 + 3N + K cycles after the `start` edge, where N is the box area and K is the number of pixels emitted.
  - With the macro on a non-degenerate triangle: 3 + 3N + K cycles.
- The first `out_valid` appears no earlier than 4 cycles after `start` (SETUP + 3 EVAL), or 5 cycles with AREA.
- There are no bubbles beyond the defined states. Back-pressure adds one cycle per cycle of `out_ready` = 0.
- `out_valid` never drops without a handshake, except on reset.

## Configuration

- **`TRI_RASTER_CULL_EN` defined:**
  - AREA state (1 cycle) is inserted after SETUP. It computes E(p1, p2, p3) on the shared unit.
  - If E == 0 (degenerate triangle), skip the scan and go straight to DONE with `pix_count` = 0.
- **Not defined:**
  - No AREA state.
  - Degenerate triangles are scanned in full. Every pixel lying on the segment(s) passes the inside rule and is emitted.

## Test plan

- **Basic scan:**
  - Stimulus: vertices (10,22), (10,25), (13,22); `out_ready` = 1.
  - Response: 16 pixels scanned, 10 emitted in raster order starting (10,22), (11,22), (12,22), (13,22), (10,23)…
  - `pix_count` = 10; `done` at 2 + 48 + 10 = 60 cycles after `start`.
- **Back-pressure:**
  - Stimulus: same triangle; `out_ready` low for 5 cycles on the 3rd pixel.
  - Response: `out_x` = 12, `out_y` = 22 held stable with `out_valid` = 1 throughout. Total latency +5, output sequence unchanged.
- **Degenerate triangle:**
  - Stimulus: all vertices (5,5).
  - Response without the macro: one pixel (5,5) emitted, `done` at cycle 6.
  - Response with `TRI_RASTER_CULL_EN`: no `out_valid`, `done` at cycle 3, `pix_count` = 0.
- **Top-edge boundary:**
  - Stimulus: vertices (2045,2047), (2047,2047), (2047,2045).
  - Response: 9 pixels scanned, 6 emitted, last is (2047,2047). Scan terminates with no wrap to 0.
- **Reset mid-scan:**
  - Stimulus: pull `rst_n` low during EMIT of the basic scan.
  - Response: all outputs 0 asynchronously. After release the block idles, and a new `start` rescans from (10,22).
- **Start while busy:**
  - Stimulus: pulse `start` with different vertices mid-scan.
  - Response: ignored; the original scan completes with identical output.
